uart_apb_master: RTL and testbench

- APB master that sits directly upstream of the UART APB slave top.
- Turns single-word command requests (valid/ready) from a host or sequencer into compliant two-phase APB transfers, e.g. TX data, control and status polls.
- Returns read data and completion to the requester on a valid/ready response channel.
- One transfer outstanding at a time.

---
 rtl/uart_apb_pkg.sv | 21 ++
 rtl/uart_apb_master.sv | 156 +++++++++++++++
 tb/tb_uart_apb_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB master.
// State encoding, UART register offsets and default bus widths.
package uart_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int unsigned APB_AW      = 32;
   localparam int unsigned APB_DW      = 32;
   localparam int unsigned APB_TIMEOUT = 256;

   localparam logic [7:0] UART_CTRL    = 8'h00;
   localparam logic [7:0] UART_TX_DATA = 8'h04;
   localparam logic [7:0] UART_RX_DATA = 8'h08;
   localparam logic [7:0] UART_STATUS  = 8'h0C;

endpackage

// File: rtl/uart_apb_master.sv
// APB master: one valid/ready command in, one two-phase APB transfer,
// one valid/ready response out. One transfer outstanding at a time.
// Ports:
//   PCLK, PRESETn              clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata   command channel
//   rsp_valid/ready/rdata/err          response channel
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request
//   PRDATA/PREADY                      APB completion
// Optional: define UART_APB_MASTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait cycles (rsp_err=1); otherwise rsp_err is 0.
module uart_apb_master
   import uart_apb_pkg::*;
#(
   parameter int unsigned AW             = APB_AW,
   parameter int unsigned DW             = APB_DW,
   parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          PSEL,
   output logic          PENABLE,
   output logic          PWRITE,
   output logic [AW-1:0] PADDR,
   output logic [DW-1:0] PWDATA,
   input  logic [DW-1:0] PRDATA,
   input  logic          PREADY
);

   // A zero limit would also give a zero-width wait counter.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   state_e        state_q, state_d;
   logic          pwrite_q, pwrite_d;
   logic [AW-1:0] paddr_q, paddr_d;
   logic [DW-1:0] pwdata_q, pwdata_d;
   logic [DW-1:0] rdata_q, rdata_d;

`ifdef UART_APB_MASTER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   // Abort on the wait cycle that would bring the count to the limit.
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rdata_d  = rdata_q;
`ifdef UART_APB_MASTER_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
`ifdef UART_APB_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_ACCESS: begin
            // Ready wins over a timeout landing on the same cycle.
            if (PREADY) begin
               state_d = ST_RESP;
               rdata_d = pwrite_q ? '0 : PRDATA;
`ifdef UART_APB_MASTER_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
`ifdef UART_APB_MASTER_TIMEOUT_EN
            else if (cnt_q == LIM) begin
               state_d = ST_RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
`ifdef UART_APB_MASTER_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= ST_IDLE;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         rdata_q  <= rdata_d;
      end
   end

`ifdef UART_APB_MASTER_TIMEOUT_EN
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Handshake and APB strobes decode straight from the state register.
   assign cmd_ready = (state_q == ST_IDLE);
   assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE   = (state_q == ST_ACCESS);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed self-checking bench for uart_apb_master.
// Define UART_APB_MASTER_TIMEOUT_EN to also cover the timeout abort.
module tb_uart_apb_master;
   import uart_apb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA = '0;
   logic          PREADY = 1'b0;

   uart_apb_master #(
      .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   int last_acc = -1;
   int exp_gap = 0;
   logic [31:0] slave_mem [16];
   logic [31:0] mem_exp [16];
   logic [31:0] JUNK = 32'hDEAD_BEEF;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   always @(negedge PCLK)
      chk("pen_no_sel", {63'd0, PENABLE & ~PSEL}, 64'd0);

   // Called just after a negedge; samples and drives on negedges.
   task automatic do_xfer(input logic wr,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input int waits,
                          input int hold);
      logic [31:0] exp_rd;
      int idx;
      idx = int'(addr[5:2]);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      rsp_ready = (hold == 0);
      chk("cmd_ready", {63'd0, cmd_ready}, 64'd1);
      @(negedge PCLK);
      if (last_acc >= 0)
         chk("gap", 64'(cyc - last_acc), 64'(exp_gap));
      last_acc = cyc;
      exp_gap  = 4 + waits + hold;
      cmd_write = ~wr;
      cmd_addr  = JUNK;
      cmd_wdata = JUNK;
      chk("setup", {60'd0, cmd_ready, PSEL, PENABLE, PWRITE},
          {60'd0, 1'b0, 1'b1, 1'b0, wr});
      chk("setup_addr", 64'(PADDR), 64'(addr));
      if (wr) chk("setup_wdata", 64'(PWDATA), 64'(wdata));
      exp_rd = wr ? 32'd0 : mem_exp[idx];
      if (wr) mem_exp[idx] = wdata;
      for (int w = 0; w <= waits; w++) begin
         @(negedge PCLK);
         chk("access", {60'd0, PSEL, PENABLE, PWRITE, rsp_valid},
             {60'd0, 1'b1, 1'b1, wr, 1'b0});
         chk("access_addr", 64'(PADDR), 64'(addr));
         PREADY = (w == waits);
         PRDATA = (w == waits) ? slave_mem[idx] : JUNK;
         if (w == waits && PWRITE)
            slave_mem[int'(PADDR[5:2])] = PWDATA;
      end
      @(negedge PCLK);
      PREADY = 1'b0;
      PRDATA = JUNK;
      chk("lat", 64'(cyc - last_acc + 1), 64'(3 + waits));
      for (int h = 0; h <= hold; h++) begin
         chk("resp", {59'd0, rsp_valid, cmd_ready, PSEL,
             PENABLE, rsp_err}, {59'd0, 5'b10000});
         chk("resp_rdata", 64'(rsp_rdata), 64'(exp_rd));
         chk("resp_addr", 64'(PADDR), 64'(addr));
         if (h < hold) @(negedge PCLK);
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      chk("done", {60'd0, rsp_valid, rsp_err, cmd_ready, PSEL},
          {60'd0, 4'b0010});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         slave_mem[k] = 32'h5A00 + k;
         mem_exp[k]   = 32'h5A00 + k;
      end
      slave_mem[3] = 32'h3C;
      mem_exp[3]   = 32'h3C;

      #1;
      chk("rst_ctl", {58'd0, cmd_ready, rsp_valid, rsp_err,
          PSEL, PENABLE, PWRITE}, {58'd0, 6'b100000});
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("rst_ctl2", {58'd0, cmd_ready, rsp_valid, rsp_err,
          PSEL, PENABLE, PWRITE}, {58'd0, 6'b100000});
      chk("rst_bus", {PADDR, PWDATA}, 64'd0);
      chk("rst_rdata", 64'(rsp_rdata), 64'd0);

      do_xfer(1'b1, 32'h4, 32'hA5, 0, 0);
      do_xfer(1'b0, 32'hC, 32'h0, 5, 0);
      do_xfer(1'b0, 32'h4, 32'h0, 1, 10);

      for (int i = 0; i < 20; i++)
         do_xfer((i % 3) != 2, 32'((i * 5) % 8) << 2,
                 32'h1000_0000 + 32'(i) * 32'h0101,
                 (i * 7) % 4, 0);

      // Asynchronous reset while the slave is stalling in ACCESS.
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h8;
      rsp_ready = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("rst_pre", {62'd0, PSEL, PENABLE}, {62'd0, 2'b11});
      #2;
      PRESETn = 1'b0;
      #1;
      chk("rst_async", {60'd0, PSEL, PENABLE, rsp_valid,
          cmd_ready}, {60'd0, 4'b0001});
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("rst_rel", {61'd0, cmd_ready, PSEL, rsp_valid},
          {61'd0, 3'b100});
      chk("rst_rel_addr", 64'(PADDR), 64'd0);
      last_acc = -1;
      do_xfer(1'b0, 32'hC, 32'h0, 2, 0);

`ifdef UART_APB_MASTER_TIMEOUT_EN
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h10;
      rsp_ready = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      for (int w = 0; w < int'(TO); w++) begin
         @(negedge PCLK);
         chk("to_access", {62'd0, PSEL, PENABLE},
             {62'd0, 2'b11});
         PREADY = 1'b0;
      end
      @(negedge PCLK);
      chk("to_resp", {61'd0, rsp_valid, rsp_err, PSEL},
          {61'd0, 3'b110});
      chk("to_rdata", 64'(rsp_rdata), 64'd0);
      rsp_ready = 1'b1;
      @(negedge PCLK);
      chk("to_done", {62'd0, rsp_valid, rsp_err}, 64'd0);
      last_acc = -1;
      do_xfer(1'b0, 32'h14, 32'h0, int'(TO) - 1, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
